// File: rtl/div_pkg.sv
// div_pkg: shared widths, reset level, divider state encoding and handshake levels
package div_pkg;
  localparam int REG_BUS = 32;
  localparam int DOUBLE_REG_BUS = 64;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP = 1'b0;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
endpackage

// File: rtl/div.sv
// div: radix-2 restoring 32-bit divider for DIV/DIVU, one quotient bit per clock
module div
  import div_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      signed_div_i,
  input  logic [REG_BUS-1:0]        opdata1_i,
  input  logic [REG_BUS-1:0]        opdata2_i,
  input  logic                      start_i,
  input  logic                      annul_i,
  output logic [DOUBLE_REG_BUS-1:0] result_o,
  output logic                      ready_o
);
  div_state_e state, state_n;
  logic [5:0] cnt, cnt_n;
  logic [REG_BUS-1:0] dvd, dvd_n, dsr, dsr_n, rem, rem_n, rem_nx, q_nx;
  logic neg_q, neg_q_n, neg_r, neg_r_n, ready_n;
  logic [DOUBLE_REG_BUS-1:0] result_n;
  logic [REG_BUS+1:0] trial;
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  assign trial = {1'b0, rem, dvd[REG_BUS-1]} - {2'b00, dsr};
  assign rem_nx = trial[REG_BUS+1] ? {rem[REG_BUS-2:0], dvd[REG_BUS-1]} : trial[REG_BUS-1:0];
  assign q_nx = {dvd[REG_BUS-2:0], ~trial[REG_BUS+1]};
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dvd_n = dvd;
    dsr_n = dsr;
    rem_n = rem;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    ready_n = ready_o;
    result_n = result_o;
    if (annul_i) begin
      state_n = DIV_FREE;
      ready_n = DIV_RESULT_NOT_READY;
      result_n = '0;
    end else begin
      case (state)
        DIV_FREE: if (start_i == DIV_START) begin
          state_n = opdata2_i == '0 ? DIV_BY_ZERO : DIV_ON;
          dvd_n = signed_div_i && opdata1_i[REG_BUS-1] ? -opdata1_i : opdata1_i;
          dsr_n = signed_div_i && opdata2_i[REG_BUS-1] ? -opdata2_i : opdata2_i;
          neg_q_n = signed_div_i && (opdata1_i[REG_BUS-1] ^ opdata2_i[REG_BUS-1]);
          neg_r_n = signed_div_i && opdata1_i[REG_BUS-1];
          cnt_n = '0;
          rem_n = '0;
        end
        DIV_BY_ZERO: begin
          state_n = DIV_END;
          ready_n = DIV_RESULT_READY;
          result_n = '0;
        end
        DIV_ON: begin
          rem_n = rem_nx;
          dvd_n = q_nx;
          cnt_n = cnt + 6'd1;
          if (cnt == 6'd31) begin
            state_n = DIV_END;
            ready_n = DIV_RESULT_READY;
            result_n = {neg_r ? -rem_nx : rem_nx, neg_q ? -q_nx : q_nx};
          end
        end
        DIV_END: if (start_i == DIV_STOP) begin
          state_n = DIV_FREE;
          ready_n = DIV_RESULT_NOT_READY;
          result_n = '0;
        end
        default: state_n = DIV_FREE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      state <= DIV_FREE;
      cnt <= '0;
      dvd <= '0;
      dsr <= '0;
      rem <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ready_o <= DIV_RESULT_NOT_READY;
      result_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dvd <= dvd_n;
      dsr <= dsr_n;
      rem <= rem_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      ready_o <= ready_n;
      result_o <= result_n;
    end
  end
endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider in the execute stage; serves DIV and DIVU. The EX stage raises `stallreq_from_ex` while `start_i` is high and `ready_o` is low. The pipeline control block then freezes PC, IF/ID, ID/EX and EX until the result returns. Radix-2 restoring algorithm: one quotient bit per clock, 64-bit {remainder, quotient} result written to HI/LO.

## Interface
- No parameters; width fixed at 32 (`RegBus`).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- start_i  in  1  request; EX holds it and operands stable until `ready_o`.
- annul_i  in  1  cancel in-flight division (exception/flush).
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while `ready_o`=1.
- ready_o  out  1  result valid.

## Operation
- States: FREE, BYZERO, ON, END. Reset (async, rst=0): state FREE, `ready_o`=0, `result_o`=0, counter 0.
- FREE: if `start_i`=1 and `annul_i`=0, then:
  - divisor 0 → BYZERO;
  - otherwise → ON.
  - On entry to ON, latch |dividend| and |divisor|, using absolute values only when `signed_div_i`=1. Also latch both operand signs and `signed_div_i`, and clear the 6-bit counter and partial remainder.
  - With `start_i`=0, stay FREE; outputs 0.
- BYZERO: → END next edge with `result_o`=0.
- ON, per cycle:
  - Form 33-bit trial = {rem[31:0], next dividend bit} − {1'b0, divisor}.
  - If the trial is non-negative: rem ← trial[31:0], quotient bit 1. Otherwise: rem ← shifted value, quotient bit 0.
  - Counter increments.
  - The iteration with counter = 31 is the 32nd. On that edge, go to END and register the sign-corrected result with `ready_o`=1.
- Sign correction (signed only):
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - −2^31 / −1 → quotient 0x80000000, remainder 0, no trap.
- END: hold `result_o` and `ready_o`=1 while `start_i`=1. When `start_i`=0 → FREE, clearing `ready_o` and `result_o`.
- `annul_i`=1 in any state → FREE next edge, `ready_o`=0, `result_o`=0, and no result is ever presented. `annul_i` takes priority over `start_i` and over completion on the same edge.
- Operand changes during ON are ignored; only values latched at acceptance matter.

## Timing
- Acceptance edge E0 (FREE, `start_i`=1).
- Normal divide: iterations on E1..E32; `ready_o`=1 after E32. Stall length is 32 cycles after the request cycle.
- Divide by zero: BYZERO after E0, END after E1; `ready_o`=1 after E1.
- Result presented until the first edge with `start_i`=0. Back-to-back divides therefore need one FREE cycle, which the pipeline guarantees because EX drops `start_i` once it sees `ready_o`.
- All outputs registered; no combinational path from inputs to outputs.
- Reset assertion mid-division aborts immediately, asynchronously. First acceptance is possible on the first edge after release.

## Structure
- Shared defines file gains:
  - `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2-bit encodings);
  - `DivResultReady`/`DivResultNotReady`;
  - `DivStart`/`DivStop`.
- Reuses existing `RegBus`, `DoubleRegBus`, `RstEnable` (1'b0 for this block's async low reset).
- Single module. No sub-module; the conditional negate is two inline expressions.

## Test plan
- Unsigned: 100 / 7, `signed_div_i`=0 → after 32 cycles `result_o`=0x00000002_0000000E, `ready_o`=1. Output holds until `start_i` drops, then 0.
- Signed: −7 (0xFFFFFFF9) / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / −2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Edge values:
  - 0x80000000 / 0xFFFFFFFF signed → {0x00000000, 0x80000000};
  - same operands unsigned → {0x80000000, 0x00000000}.
- Divide by zero: 5 / 0 → `ready_o`=1 two edges after acceptance, `result_o`=0.
- Annul at iteration 10 → FREE next edge, `ready_o` never asserts. A fresh 9/3 started the following cycle returns {0, 3} with full 32-cycle latency.
- Reset: drive rst=0 at iteration 20 → outputs 0 immediately, without waiting for a clock edge. After release, 0xFFFFFFFF / 1 unsigned → {0, 0xFFFFFFFF}.
